// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, opcodes,
// ALU unit encodings and the decoded control word.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_NAND = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_LD   = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_MUL  = 4'h9,
        OP_LDI  = 4'hA,
        OP_ST   = 4'hB,
        OP_BNEZ = 4'hC,
        OP_JMP  = 4'hD,
        OP_NOP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    localparam logic [2:0] U_ADD     = 3'b000;
    localparam logic [2:0] U_LOGIC   = 3'b001;
    localparam logic [2:0] U_SHIFT   = 3'b010;
    localparam logic [2:0] U_LOAD    = 3'b011;
    localparam logic [2:0] U_OR      = 3'b100;
    localparam logic [2:0] U_XOR     = 3'b101;
    localparam logic [2:0] U_MUL     = 3'b110;
    localparam logic [2:0] U_PASSACC = 3'b111;

    localparam logic [7:0] INSTR_NOP = 8'hE0;

    typedef struct packed {
        logic [2:0] unit_sel;
        logic       op_sel;
        logic       imm_sel;
        logic       acc_we;
        logic       rf_we;
        logic       is_bnez;
        logic       is_jmp;
        logic       is_halt;
    } ctrl_t;

    // Control word that leaves the ALU passing the accumulator and touches nothing.
    function automatic ctrl_t ctrl_quiet();
        ctrl_t c;
        c          = '0;
        c.unit_sel = U_PASSACC;
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: maps the 4-bit opcode onto the ALU control word.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = ctrl_quiet();
        case (opcode)
            OP_ADD:  begin ctrl.unit_sel = U_ADD;   ctrl.acc_we = 1'b1; end
            OP_SUB:  begin ctrl.unit_sel = U_ADD;   ctrl.op_sel = 1'b1; ctrl.acc_we = 1'b1; end
            OP_AND:  begin ctrl.unit_sel = U_LOGIC; ctrl.acc_we = 1'b1; end
            OP_NAND: begin ctrl.unit_sel = U_LOGIC; ctrl.op_sel = 1'b1; ctrl.acc_we = 1'b1; end
            OP_SHL:  begin ctrl.unit_sel = U_SHIFT; ctrl.acc_we = 1'b1; end
            OP_SHR:  begin ctrl.unit_sel = U_SHIFT; ctrl.op_sel = 1'b1; ctrl.acc_we = 1'b1; end
            OP_LD:   begin ctrl.unit_sel = U_LOAD;  ctrl.acc_we = 1'b1; end
            OP_OR:   begin ctrl.unit_sel = U_OR;    ctrl.acc_we = 1'b1; end
            OP_XOR:  begin ctrl.unit_sel = U_XOR;   ctrl.acc_we = 1'b1; end
            OP_MUL:  begin ctrl.unit_sel = U_MUL;   ctrl.acc_we = 1'b1; end
            // LDI reuses the load unit but sources the immediate instead of the register file
            OP_LDI:  begin ctrl.unit_sel = U_LOAD;  ctrl.imm_sel = 1'b1; ctrl.acc_we = 1'b1; end
            OP_ST:   ctrl.rf_we   = 1'b1;
            OP_BNEZ: ctrl.is_bnez = 1'b1;
            OP_JMP:  ctrl.is_jmp  = 1'b1;
            OP_NOP:  ctrl.unit_sel = U_PASSACC;
            OP_HALT: ctrl.is_halt = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle IDLE/FETCH/EXEC control unit for the 8-bit ALU; owns pc, acc and the
// instruction register and drives the ALU and register-file control signals.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            start_in,
    output logic            imem_req_out,
    output logic [PC_W-1:0] imem_addr_out,
    input  logic            imem_valid_in,
    input  logic [7:0]      imem_data_in,
    output logic [3:0]      rf_addr_out,
    output logic            rf_we_out,
    output logic [7:0]      rf_wdata_out,
    output logic            imm_sel_out,
    output logic [7:0]      imm_out,
    output logic [2:0]      unit_sel_out,
    output logic            op_sel_out,
    input  logic [7:0]      alu_res_in,
    output logic [7:0]      acc_out,
    output logic [PC_W-1:0] pc_out,
    output logic            busy_out,
    output logic            done_out
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [7:0]      acc;
    logic [7:0]      instr;
    logic            done;
    ctrl_t           ctrl;
    logic            exec;
    logic signed [3:0] br_off;
    logic [PC_W-1:0] br_off_ext;
    logic [PC_W-1:0] pc_next;

    alu_seq_decode u_decode (
        .opcode (instr[7:4]),
        .ctrl   (ctrl)
    );

    assign exec       = (state == EXEC);
    assign br_off     = $signed(instr[3:0]);
    assign br_off_ext = PC_W'(br_off);

    // Branch offsets are relative to the branch itself, so a zero offset spins in place.
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (ctrl.is_halt)
            pc_next = pc;
        else if (ctrl.is_jmp)
            pc_next = PC_W'(instr[3:0]);
        else if (ctrl.is_bnez && (acc != 8'h00))
            pc_next = pc + br_off_ext;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            pc    <= '0;
            acc   <= '0;
            instr <= INSTR_NOP;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        pc    <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_valid_in) begin
                        instr <= imem_data_in;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (ctrl.acc_we)
                        acc <= alu_res_in;
                    pc <= pc_next;
                    if (ctrl.is_halt) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req_out  = (state == FETCH);
    assign imem_addr_out = pc;
    assign pc_out        = pc;
    assign acc_out       = acc;
    assign rf_wdata_out  = acc;
    assign rf_addr_out   = instr[3:0];
    assign imm_out       = {4'h0, instr[3:0]};
    assign busy_out      = (state != IDLE);
    assign done_out      = done;

    // Decode only reaches the ALU and register file while executing.
    assign unit_sel_out = exec ? ctrl.unit_sel : U_PASSACC;
    assign op_sel_out   = exec & ctrl.op_sel;
    assign imm_sel_out  = exec & ctrl.imm_sel;
    assign rf_we_out    = exec & ctrl.rf_we;

endmodule
